imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Decode-stage immediate generator, parametrised successor to the single-cycle extender.
//  Accepts instr[31:7] plus format code over valid/ready, outputs the XLEN-wide immediate.
//  Covers every RV format (I/S/B/U/J/shamt) and flags illegal codes.
//  Registered output with a 2-entry skid buffer, so decode->execute back-pressure is lossless.
// PARAMETERS
//  XLEN    32  immediate width; 32 or 64 only
//  TAG_W   5   width of sideband tag (e.g. rd/ROB id), passed through unchanged
//  EN_UJ   1   1: U/J formats decoded; 0: codes 100/101 reported illegal
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high
//  flush        in   1        drop all held entries (branch redirect)
//  in_valid     in   1        input entry valid
//  in_ready     out  1        block can accept; transfer when in_valid&in_ready
//  in_instr     in   25       instruction bits [31:7]
//  in_imm_src   in   3        format code (see BEHAVIOUR)
//  in_tag       in   TAG_W    sideband tag
//  out_valid    out  1        output entry valid
//  out_ready    in   1        consumer accepts; transfer when out_valid&out_ready
//  out_imm      out  XLEN     sign/zero-extended immediate
//  out_tag      out  TAG_W    tag of the output entry
//  out_illegal  out  1        format code was illegal; out_imm is 0
// BEHAVIOUR
//  Formats (i = in_instr, sx = sign-extend to XLEN from i[31]):
//   000 none -> 0 | 001 I sx{i[31:20]} | 010 S sx{i[31:25],i[11:7]}
//   011 B sx{i[31],i[7],i[30:25],i[11:8],0} | 100 U sx{i[31:12],12'b0}
//   101 J sx{i[31],i[19:12],i[20],i[30:21],0}
//   110 shamt zero-ext: i[24:20] (XLEN=32) / i[25:20] (XLEN=64)
//   111 illegal -> imm 0, illegal=1; 100/101 likewise when EN_UJ=0
//  Datapath: formatter is combinational on the input; the result is captured in main reg (M).
//   Skid reg (S) sits behind M. Latency in->out = 1 cycle when not stalled.
//  FSM (state = occupancy):
//   EMPTY: in xfer -> ONE (M loaded)
//   ONE:   in xfer & out xfer -> ONE (M reloaded); in only -> FULL (S loaded);
//          out only -> EMPTY
//   FULL:  out xfer -> ONE (S moves to M); no input accepted
//  in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. out_valid = (state != EMPTY).
//  Order strictly FIFO; no entry dropped or duplicated except by flush/reset.
//  out_* are stable while out_valid & !out_ready.
//  flush: next state EMPTY, in_ready=1. An input presented in the flush cycle is dropped.
//   An output transfer in the flush cycle still counts as completed.
//  reset (overrides flush): state EMPTY, in_ready=1, out_valid=0, out_imm=0,
//   out_tag=0, out_illegal=0. Reset mid-stall discards M and S.
//   Handshakes in the reset cycle are ignored.
//  XLEN other than 32/64: elaboration error.
// STRUCTURE
//  imm_pkg: IMM_NONE/I/S/B/U/J/SHAMT/ILL 3-bit localparams, state encoding.
//  Sub-module imm_ext_comb #(XLEN,EN_UJ): pure combinational formatter (imm, illegal).
//  Top: FSM, M/S registers, handshake logic.
// TESTING
//  XLEN=32, I 0xFFF00093[31:7], out_ready=1 -> next cycle out_imm=0xFFFFFFFF, illegal=0
//  S from 0xFE112E23 -> 0xFFFFFFFC. U from 0x12345037 -> 0x12345000.
//   J/B: all-ones offset fields -> 0xFFFFFFFE
//  XLEN=64, U from 0x80000037 -> 0xFFFFFFFF80000000. shamt i[25:20]=0x3F -> 0x3F
//  out_ready=0, tags 1,2,3 offered back-to-back -> 1,2 accepted, in_ready=0 from cycle 2;
//   out_ready=1 -> tags 1,2,3 emerge in order, no gaps after release
//  FULL state + flush, with in_valid=1 in the same cycle -> next cycle out_valid=0,
//   in_ready=1, flushed input never appears
//  code 111, and EN_UJ=0 with code 101 -> out_imm=0, out_illegal=1.
//   reset asserted in FULL -> all outputs at reset values next cycle

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes and
// the occupancy state encoding of the output buffer.
package imm_pkg;

    localparam logic [2:0] IMM_NONE  = 3'b000;
    localparam logic [2:0] IMM_I     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;
    localparam logic [2:0] IMM_SHAMT = 3'b110;
    localparam logic [2:0] IMM_ILL   = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational immediate formatter: instr[31:7] plus format code to an
// XLEN-wide sign/zero-extended immediate, with an illegal-code flag.
module imm_ext_comb
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit EN_UJ = 1'b1
) (
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // instr[k] holds architectural bit k+7
    logic [31:0] lo;
    logic        hi;

    always_comb begin
        lo      = '0;
        hi      = 1'b0;
        illegal = 1'b0;
        case (imm_src)
            IMM_NONE: ;
            IMM_I: begin
                lo = {{20{instr[24]}}, instr[24:13]};
                hi = instr[24];
            end
            IMM_S: begin
                lo = {{20{instr[24]}}, instr[24:18], instr[4:0]};
                hi = instr[24];
            end
            IMM_B: begin
                lo = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
                hi = instr[24];
            end
            IMM_U: begin
                if (EN_UJ) begin
                    lo = {instr[24:5], 12'b0};
                    hi = instr[24];
                end else begin
                    illegal = 1'b1;
                end
            end
            IMM_J: begin
                if (EN_UJ) begin
                    lo = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
                    hi = instr[24];
                end else begin
                    illegal = 1'b1;
                end
            end
            IMM_SHAMT: lo = (XLEN == 64) ? {26'b0, instr[18:13]} : {27'b0, instr[17:13]};
            default:   illegal = 1'b1;
        endcase
    end

    // upper half only exists for XLEN=64; the loop is empty at XLEN=32
    always_comb begin
        imm       = '0;
        imm[31:0] = lo;
        for (int unsigned k = 32; k < XLEN; k++) imm[k] = hi;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator with registered output and a 2-entry
// skid buffer (main M, skid S) under valid/ready handshakes on both sides.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter bit EN_UJ = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    state_t state, state_next;
    logic   in_xfer, out_xfer;
    logic   load_m_in, load_m_s, load_s_in;

    logic [XLEN-1:0]  ext_imm, m_imm, s_imm;
    logic             ext_ill, m_ill, s_ill;
    logic [TAG_W-1:0] m_tag, s_tag;

    imm_ext_comb #(
        .XLEN (XLEN),
        .EN_UJ(EN_UJ)
    ) u_ext (
        .instr  (in_instr),
        .imm_src(in_imm_src),
        .imm    (ext_imm),
        .illegal(ext_ill)
    );

    assign out_valid   = (state != ST_EMPTY);
    assign in_xfer     = in_valid & in_ready;
    assign out_xfer    = out_valid & out_ready;
    assign out_imm     = m_imm;
    assign out_tag     = m_tag;
    assign out_illegal = m_ill;

    always_comb begin
        state_next = state;
        load_m_in  = 1'b0;
        load_m_s   = 1'b0;
        load_s_in  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_next = ST_ONE;
                    load_m_in  = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_m_in = 1'b1;
                end else if (in_xfer) begin
                    state_next = ST_FULL;
                    load_s_in  = 1'b1;
                end else if (out_xfer) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    state_next = ST_ONE;
                    load_m_s   = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        // flush drops held entries and any input offered this cycle
        if (flush) begin
            state_next = ST_EMPTY;
            load_m_in  = 1'b0;
            load_m_s   = 1'b0;
            load_s_in  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            m_imm    <= '0;
            m_tag    <= '0;
            m_ill    <= 1'b0;
            s_imm    <= '0;
            s_tag    <= '0;
            s_ill    <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != ST_FULL);
            if (load_m_in) begin
                m_imm <= ext_imm;
                m_tag <= in_tag;
                m_ill <= ext_ill;
            end else if (load_m_s) begin
                m_imm <= s_imm;
                m_tag <= s_tag;
                m_ill <= s_ill;
            end
            if (load_s_in) begin
                s_imm <= ext_imm;
                s_tag <= in_tag;
                s_ill <= ext_ill;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: format table across XLEN=32, XLEN=64 and
// EN_UJ=0 instances, then back-pressure, flush and reset sequences.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [24:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;

    logic        rdy32, rdy64, rdyn;
    logic        ov32, ov64, ovn;
    logic [31:0] imm32, immn;
    logic [63:0] imm64;
    logic [4:0]  tag32, tag64, tagn;
    logic        ill32, ill64, illn;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .EN_UJ(1'b1)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov32),
        .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .EN_UJ(1'b1)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ov64),
        .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64));

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .EN_UJ(1'b0)) dutn (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdyn),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag), .out_valid(ovn),
        .out_ready(out_ready), .out_imm(immn), .out_tag(tagn), .out_illegal(illn));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        ill;
        logic        ill_nouj;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [4:0] tag);
        in_valid   = v;
        in_instr   = instr[31:7];
        in_imm_src = src;
        in_tag     = tag;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'b001, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        vecs[1]  = '{32'hFE112E23, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
        vecs[2]  = '{32'h12345037, 3'b100, 32'h12345000, 64'h0000000012345000, 1'b0, 1'b1};
        vecs[3]  = '{32'hFFFFF06F, 3'b101, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1};
        vecs[4]  = '{32'hFE000FE3, 3'b011, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0};
        vecs[5]  = '{32'h80000037, 3'b100, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b1};
        vecs[6]  = '{32'h03F00013, 3'b110, 32'h0000001F, 64'h000000000000003F, 1'b0, 1'b0};
        vecs[7]  = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1, 1'b1};
        vecs[8]  = '{32'hFFFFFFFF, 3'b000, 32'h00000000, 64'h0000000000000000, 1'b0, 1'b0};
        vecs[9]  = '{32'h00100000, 3'b101, 32'h00000800, 64'h0000000000000800, 1'b0, 1'b1};
        vecs[10] = '{32'h00000080, 3'b011, 32'h00000800, 64'h0000000000000800, 1'b0, 1'b0};
        vecs[11] = '{32'h7FF00000, 3'b001, 32'h000007FF, 64'h00000000000007FF, 1'b0, 1'b0};
        vecs[12] = '{32'h80000000, 3'b010, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 1'b0, 1'b0};

        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'hFFF00093, 3'b001, 5'd9);
        step(); step();
        chk("rst_in_ready",  64'(rdy32), 64'd1);
        chk("rst_out_valid", 64'(ov32),  64'd0);
        chk("rst_imm",       64'(imm32), 64'd0);
        chk("rst_tag",       64'(tag32), 64'd0);
        chk("rst_illegal",   64'(ill32), 64'd0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 5'd0);
        step();
        chk("idle_out_valid", 64'(ov32), 64'd0);

        // back-to-back stream, consumer always ready: one cycle latency
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].src, 5'(i));
            step();
            chk($sformatf("v%0d_valid", i), 64'(ov32 & ov64 & ovn), 64'd1);
            chk($sformatf("v%0d_tag", i),   64'(tag32), 64'(i));
            chk($sformatf("v%0d_imm32", i), 64'(imm32), 64'(vecs[i].e32));
            chk($sformatf("v%0d_ill32", i), 64'(ill32), 64'(vecs[i].ill));
            chk($sformatf("v%0d_imm64", i), imm64,      vecs[i].e64);
            chk($sformatf("v%0d_ill64", i), 64'(ill64), 64'(vecs[i].ill));
            chk($sformatf("v%0d_immn", i),  64'(immn),  vecs[i].ill_nouj ? 64'd0 : 64'(vecs[i].e32));
            chk($sformatf("v%0d_illn", i),  64'(illn),  64'(vecs[i].ill_nouj));
        end
        drive(1'b0, 32'h0, 3'b000, 5'd0);
        step();
        chk("drain_valid", 64'(ov32), 64'd0);

        // back-pressure: tags 1,2 accepted, 3 waits, then all emerge in order
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 3'b001, 5'd1);
        step();
        chk("bp1_valid", 64'(ov32), 64'd1);
        chk("bp1_tag",   64'(tag32), 64'd1);
        chk("bp1_ready", 64'(rdy32), 64'd1);
        drive(1'b1, 32'h00200093, 3'b001, 5'd2);
        step();
        chk("bp2_tag",   64'(tag32), 64'd1);
        chk("bp2_ready", 64'(rdy32), 64'd0);
        drive(1'b1, 32'h00300093, 3'b001, 5'd3);
        step();
        chk("bp3_tag",   64'(tag32), 64'd1);
        chk("bp3_imm",   64'(imm32), 64'd1);
        chk("bp3_ready", 64'(rdy32), 64'd0);
        out_ready = 1'b1;
        step();
        chk("rel1_tag",   64'(tag32), 64'd2);
        chk("rel1_imm",   64'(imm32), 64'd2);
        chk("rel1_ready", 64'(rdy32), 64'd1);
        step();
        chk("rel2_valid", 64'(ov32), 64'd1);
        chk("rel2_tag",   64'(tag32), 64'd3);
        chk("rel2_imm",   64'(imm32), 64'd3);
        drive(1'b0, 32'h0, 3'b000, 5'd0);
        step();
        chk("rel3_valid", 64'(ov32), 64'd0);

        // flush while FULL with a new input offered in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h00400093, 3'b001, 5'd4);
        step();
        drive(1'b1, 32'h00500093, 3'b001, 5'd5);
        step();
        chk("fl_full_ready", 64'(rdy32), 64'd0);
        drive(1'b1, 32'h00600093, 3'b001, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", 64'(ov32), 64'd0);
        chk("fl_ready", 64'(rdy32), 64'd1);
        drive(1'b0, 32'h0, 3'b000, 5'd0);
        out_ready = 1'b1;
        step();
        chk("fl_after1_valid", 64'(ov32), 64'd0);
        step();
        chk("fl_after2_valid", 64'(ov32), 64'd0);

        // reset while FULL discards both entries
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'b001, 5'd7);
        step();
        drive(1'b1, 32'hFFF00093, 3'b001, 5'd8);
        step();
        chk("rf_full_ready", 64'(rdy32), 64'd0);
        chk("rf_full_imm",   64'(imm32), 64'hFFFFFFFF);
        drive(1'b1, 32'hFFFFFFFF, 3'b111, 5'd9);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 5'd0);
        chk("rf_ready",   64'(rdy32), 64'd1);
        chk("rf_valid",   64'(ov32),  64'd0);
        chk("rf_imm",     64'(imm32), 64'd0);
        chk("rf_imm64",   imm64,      64'd0);
        chk("rf_tag",     64'(tag32), 64'd0);
        chk("rf_illegal", 64'(ill32), 64'd0);
        step();
        chk("rf_after_valid", 64'(ov32), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
